// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
// Optional feature macro used by the top: VEDIC_SIGNED_EN.
package vedic_pkg;

  // Width of the base partial products formed in stage 1.
  localparam int BASE_W = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Pipeline depth: one register per recursion level, 2x2 up to WxW.
  function automatic int VEDIC_LAT(input int w);
    return clog2(w);
  endfunction

  // Bits held by stage s (1-based): (W/2^s)^2 products of 2^(s+1) bits each.
  function automatic int stage_bits(input int w, input int s);
    return (2 * w * w) >> s;
  endfunction

  // Offset of stage s inside the flattened pipeline vector.
  function automatic int stage_off(input int w, input int s);
    return (2 * w * w) - ((2 * w * w) >> (s - 1));
  endfunction

endpackage

// File: rtl/vedic_combine_level.sv
// One recursion level of the Vedic multiplier: combines groups of four
// half-width partial products into full-width products and registers them.
// Products are stored row-major by (a-chunk, b-chunk) index, LSB chunk first.
module vedic_combine_level
  import vedic_pkg::*;
#(
  parameter int LVL_W = 4,
  parameter int NPROD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [4*NPROD*LVL_W-1:0]   in_p,
  output logic [2*NPROD*LVL_W-1:0]   out_p
);

  localparam int H  = LVL_W / 2;
  localparam int PW = 2 * LVL_W;
  localparam int S  = 1 << (clog2(NPROD) / 2);
  localparam int CS = 2 * S;

  logic [2*NPROD*LVL_W-1:0] sum;

  for (genvar gi = 0; gi < S; gi++) begin : g_row
    for (genvar gj = 0; gj < S; gj++) begin : g_col
      localparam int O  = gi * S + gj;
      localparam int LL = (2 * gi) * CS + 2 * gj;
      localparam int HL = (2 * gi + 1) * CS + 2 * gj;
      localparam int LH = (2 * gi) * CS + 2 * gj + 1;
      localparam int HH = (2 * gi + 1) * CS + 2 * gj + 1;

      logic [PW-1:0] pll, phl, plh, phh;
      assign pll = {{LVL_W{1'b0}}, in_p[LL*LVL_W +: LVL_W]};
      assign phl = {{LVL_W{1'b0}}, in_p[HL*LVL_W +: LVL_W]};
      assign plh = {{LVL_W{1'b0}}, in_p[LH*LVL_W +: LVL_W]};
      assign phh = {{LVL_W{1'b0}}, in_p[HH*LVL_W +: LVL_W]};

      // Full-width sum; the cross terms cannot overflow PW bits.
      assign sum[O*PW +: PW] = pll + ((phl + plh) << H) + (phh << LVL_W);
    end
  end

  // Register the combined products; hold while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p <= '0;
    end else if (en) begin
      out_p <= sum;
    end
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready handshake.
// Latency log2(WIDTH); the whole pipe freezes while the output is stalled.
// Define VEDIC_SIGNED_EN to add the in_signed port and two's complement mode.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LAT = VEDIC_LAT(WIDTH);
  localparam int NB  = WIDTH / BASE_W;
  localparam int PB  = 2 * BASE_W;
  localparam int TOT = stage_off(WIDTH, LAT + 1);

  logic                 stall;
  logic                 adv;
  logic [WIDTH-1:0]     opa, opb;
  logic [WIDTH*WIDTH-1:0] base_nxt, base_q;
  logic [TOT-1:0]       pipe;
  logic [2*WIDTH-1:0]   prod;
  logic [LAT-1:0]       vld;
  logic [TAG_W-1:0]     tagq [LAT];

  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld[LAT-1];
  assign out_tag   = tagq[LAT-1];

`ifdef VEDIC_SIGNED_EN
  logic           sgn_in;
  logic [LAT-1:0] sgn;

  // Magnitudes feed the unsigned core; the most negative value maps to 2^(W-1).
  assign opa    = (in_signed & a[WIDTH-1]) ? -a : a;
  assign opb    = (in_signed & b[WIDTH-1]) ? -b : b;
  assign sgn_in = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

  // Sign flag rides alongside the valid chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn <= '0;
    end else if (adv) begin
      sgn <= {sgn[LAT-2:0], sgn_in};
    end
  end

  assign result = sgn[LAT-1] ? -prod : prod;
`else
  assign opa    = a;
  assign opb    = b;
  assign result = prod;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_ba
    for (genvar j = 0; j < NB; j++) begin : g_bb
      assign base_nxt[(i*NB+j)*PB +: PB] =
        {{BASE_W{1'b0}}, opa[i*BASE_W +: BASE_W]} *
        {{BASE_W{1'b0}}, opb[j*BASE_W +: BASE_W]};
    end
  end

  // Stage 1: register every 2x2 base product.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
    end else if (adv) begin
      base_q <= base_nxt;
    end
  end

  assign pipe[WIDTH*WIDTH-1:0] = base_q;

  for (genvar s = 2; s <= LAT; s++) begin : g_lvl
    vedic_combine_level #(
      .LVL_W (1 << s),
      .NPROD ((WIDTH >> s) * (WIDTH >> s))
    ) u_lvl (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .in_p  (pipe[stage_off(WIDTH, s-1) +: stage_bits(WIDTH, s-1)]),
      .out_p (pipe[stage_off(WIDTH, s)   +: stage_bits(WIDTH, s)])
    );
  end

  assign prod = pipe[TOT-1 -: 2*WIDTH];

  // Valid and tag shift chain, frozen together with the data stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) tagq[k] <= '0;
    end else if (adv) begin
      vld     <= {vld[LAT-2:0], in_valid};
      tagq[0] <= in_tag;
      for (int k = 1; k < LAT; k++) tagq[k] <= tagq[k-1];
    end
  end

endmodule
